// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler
//   Time-multiplexes two HC-SR04-style ultrasonic sensors so their pings never
//   overlap. Each slot fires one trigger pulse, waits for the echo to rise,
//   measures the echo-high time in units of DIV clock cycles, then holds a
//   quiet gap before handing the next slot to the other sensor.
//
// Ports
//   CLK     system clock
//   RESET   synchronous, active-high reset
//   enable  run the ping schedule; sampled only when leaving IDLE or GAP
//   echo    raw asynchronous echo pins, bit i = sensor i
//   trig    trigger pins, bit i = sensor i
//   dist0   last valid distance of sensor 0
//   dist1   last valid distance of sensor 1
//   valid   one-cycle strobe, bit i pulses together with a new dist_i
//   tmo     sticky timeout flag per sensor, cleared by that sensor's next valid
//   busy    high whenever the scheduler is not IDLE
//   sel     sensor that owns the current slot
module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES  = 1000,
    parameter int DIV          = 100,
    parameter int RISE_TIMEOUT = 100000,
    parameter int ECHO_TIMEOUT = 2500000,
    parameter int GAP_CYCLES   = 500000,
    parameter int DW           = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          enable,
    input  logic [1:0]    echo,
    output logic [1:0]    trig,
    output logic [DW-1:0] dist0,
    output logic [DW-1:0] dist1,
    output logic [1:0]    valid,
    output logic [1:0]    tmo,
    output logic          busy,
    output logic          sel
);

    // One shared slot counter, wide enough for the longest phase so it never wraps.
    localparam int M1   = (RISE_TIMEOUT > ECHO_TIMEOUT) ? RISE_TIMEOUT : ECHO_TIMEOUT;
    localparam int M2   = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int CMAX = (M2 > TRIG_CYCLES) ? M2 : TRIG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TIMEOUT - 1);
    localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    es_p0, es_p1;
    logic          es_sel;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic          sel_nxt;
    logic          dist_ld;
    logic          tmo_set;

    // Accumulator increment that sticks at all-ones instead of wrapping.
    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the selected sensor's synchronized echo is ever looked at.
    assign es_sel = es_p1[sel];
    assign trig   = (state == TRIG) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign busy   = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pre_nxt   = pre;
        acc_nxt   = acc;
        sel_nxt   = sel;
        dist_ld   = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = TRIG;
                    cnt_nxt   = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nxt = WAIT_RISE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (es_sel) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = '0;
                    pre_nxt   = '0;
                    acc_nxt   = '0;
                end else if (cnt == RISE_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            MEASURE: begin
                // A falling edge is checked first, so a completed echo beats
                // a timeout landing in the same cycle.
                if (!es_sel) begin
                    dist_ld   = 1'b1;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == ECHO_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (pre == DIV_LAST) begin
                        pre_nxt = '0;
                        acc_nxt = sat_inc(acc);
                    end else begin
                        pre_nxt = pre + 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    sel_nxt   = ~sel;
                    cnt_nxt   = '0;
                    state_nxt = enable ? TRIG : IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            es_p0 <= '0;
            es_p1 <= '0;
            cnt   <= '0;
            pre   <= '0;
            acc   <= '0;
            sel   <= 1'b0;
            dist0 <= '0;
            dist1 <= '0;
            valid <= '0;
            tmo   <= '0;
        end else begin
            // p0 -> p1: two-flop synchronizer for the asynchronous echo pins
            es_p0 <= echo;
            es_p1 <= es_p0;
            cnt   <= cnt_nxt;
            pre   <= pre_nxt;
            acc   <= acc_nxt;
            sel   <= sel_nxt;
            valid <= '0;
            // Distance and its strobe are registered together so valid lines
            // up with the new value.
            if (dist_ld) begin
                if (sel) begin
                    dist1    <= acc;
                    valid    <= 2'b10;
                    tmo[1]   <= 1'b0;
                end else begin
                    dist0    <= acc;
                    valid    <= 2'b01;
                    tmo[0]   <= 1'b0;
                end
            end
            if (tmo_set) tmo[sel] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
module tb_ultrasonic_scheduler;

    localparam int TRIG_CYCLES  = 4;
    localparam int DIV          = 2;
    localparam int RISE_TIMEOUT = 50;
    localparam int ECHO_TIMEOUT = 200;
    localparam int GAP_CYCLES   = 8;
    localparam int DW           = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          enable;
    logic [1:0]    echo;
    logic [1:0]    trig;
    logic [DW-1:0] dist0, dist1;
    logic [1:0]    valid, tmo;
    logic          busy, sel;

    ultrasonic_scheduler #(
        .TRIG_CYCLES(TRIG_CYCLES), .DIV(DIV), .RISE_TIMEOUT(RISE_TIMEOUT),
        .ECHO_TIMEOUT(ECHO_TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .DW(DW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .echo(echo), .trig(trig),
        .dist0(dist0), .dist1(dist1), .valid(valid), .tmo(tmo), .busy(busy), .sel(sel)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: what each sensor's outputs should hold, following the
    // slot rules (good echo -> width/DIV and tmo clear; timeout -> tmo set).
    logic [DW-1:0] exp_dist [2];
    logic [1:0]    exp_tmo;
    int            exp_sel;
    int            vexp [2];

    // Observed valid pulses and illegal double triggers.
    int vcnt [2];
    int both_trig = 0;

    always @(negedge CLK) begin
        if (valid[0]) vcnt[0]++;
        if (valid[1]) vcnt[1]++;
        if (trig == 2'b11) both_trig++;
    end

    // kind: 0 = good echo, 1 = no echo, 2 = echo held past ECHO_TIMEOUT.
    // The slot always belongs to exp_sel; the other sensor's pin gets random noise.
    task automatic run_slot(input int kind, input int dly, input int width, input bit drop_en);
        int s, o, n, w;
        bit other_seen;
        bit idle_ok;
        s = exp_sel;
        o = 1 - s;
        other_seen = 0;
        n = 0;
        while (!trig[s] && n < 200) begin
            echo[o] = 1'($urandom_range(0, 1));
            @(negedge CLK);
            n++;
            if (trig[o]) other_seen = 1;
        end
        checks++;
        if (!trig[s]) begin errors++; $display("FAIL slot_trig_start s=%0d trig=%b required bit set", s, trig); end
        checks++;
        if (sel !== 1'(s)) begin errors++; $display("FAIL slot_sel got %0d required %0d", sel, s); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL slot_busy got %b required 1", busy); end
        w = 0;
        while (trig[s] && w < 20) begin
            if (trig[o]) other_seen = 1;
            echo[o] = 1'($urandom_range(0, 1));
            @(negedge CLK);
            w++;
        end
        checks++;
        if (w != TRIG_CYCLES) begin errors++; $display("FAIL trig_width s=%0d got %0d required %0d", s, w, TRIG_CYCLES); end
        checks++;
        if (other_seen) begin errors++; $display("FAIL trig_other s=%0d other trigger fired got 1 required 0", s); end

        if (kind == 1) begin
            n = 0;
            while (!tmo[s] && n < RISE_TIMEOUT + 20) begin
                echo[o] = 1'($urandom_range(0, 1));
                @(negedge CLK);
                n++;
            end
            echo[o] = 1'b0;
            exp_tmo[s] = 1'b1;
            checks++;
            if (tmo[s] !== 1'b1 || n < RISE_TIMEOUT - 1 || n > RISE_TIMEOUT + 1) begin
                errors++;
                $display("FAIL rise_timeout s=%0d tmo=%b after %0d cycles required 1 after ~%0d", s, tmo[s], n, RISE_TIMEOUT);
            end
        end else begin
            repeat (dly) begin
                echo[o] = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            echo[s] = 1'b1;
            if (drop_en) enable = 1'b0;
            if (kind == 0) begin
                repeat (width) begin
                    echo[o] = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                end
                echo = 2'b00;
                n = 0;
                while (!valid[s] && n < 10) begin @(negedge CLK); n++; end
                exp_dist[s] = DW'(width / DIV);
                exp_tmo[s]  = 1'b0;
                vexp[s]++;
                checks++;
                if (valid[s] !== 1'b1) begin errors++; $display("FAIL valid_pulse s=%0d got 0 required 1", s); end
                checks++;
                if ((s == 0 ? dist0 : dist1) !== exp_dist[s]) begin
                    errors++;
                    $display("FAIL dist_on_valid s=%0d got %0d required %0d", s, (s == 0 ? dist0 : dist1), exp_dist[s]);
                end
                @(negedge CLK);
                checks++;
                if (valid !== 2'b00) begin errors++; $display("FAIL valid_single s=%0d got %b required 00", s, valid); end
            end else begin
                n = 0;
                while (!tmo[s] && n < width) begin
                    echo[o] = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                    n++;
                end
                checks++;
                if (tmo[s] !== 1'b1 || n < ECHO_TIMEOUT || n > ECHO_TIMEOUT + 4) begin
                    errors++;
                    $display("FAIL echo_timeout s=%0d tmo=%b after %0d cycles required 1 after ~%0d", s, tmo[s], n, ECHO_TIMEOUT);
                end
                while (n < width) begin
                    echo[o] = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                    n++;
                end
                echo = 2'b00;
                exp_tmo[s] = 1'b1;
                repeat (4) @(negedge CLK);
            end
        end

        checks++;
        if (dist0 !== exp_dist[0] || dist1 !== exp_dist[1]) begin
            errors++;
            $display("FAIL dist_regs got %0d/%0d required %0d/%0d", dist0, dist1, exp_dist[0], exp_dist[1]);
        end
        checks++;
        if (tmo !== exp_tmo) begin errors++; $display("FAIL tmo_flags got %b required %b", tmo, exp_tmo); end
        checks++;
        if (vcnt[0] != vexp[0] || vcnt[1] != vexp[1]) begin
            errors++;
            $display("FAIL valid_count got %0d/%0d required %0d/%0d", vcnt[0], vcnt[1], vexp[0], vexp[1]);
        end
        exp_sel = o;

        if (drop_en) begin
            n = 0;
            while (busy && n < 40) begin @(negedge CLK); n++; end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL park_idle got busy=%b required 0", busy); end
            checks++;
            if (sel !== 1'(exp_sel)) begin errors++; $display("FAIL park_sel got %0d required %0d", sel, exp_sel); end
            idle_ok = 1;
            repeat (5) begin
                @(negedge CLK);
                if (busy || trig != 2'b00) idle_ok = 0;
            end
            checks++;
            if (!idle_ok) begin errors++; $display("FAIL idle_hold got busy/trig activity required none"); end
            enable = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET  = 1'b1;
        enable = 1'b0;
        echo   = 2'b00;
        exp_dist[0] = '0;
        exp_dist[1] = '0;
        exp_tmo = 2'b00;
        exp_sel = 0;
        vexp[0] = 0;
        vexp[1] = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (trig !== 2'b00 || valid !== 2'b00 || tmo !== 2'b00) begin
            errors++; $display("FAIL reset_pins got trig=%b valid=%b tmo=%b required 00/00/00", trig, valid, tmo);
        end
        checks++;
        if (dist0 !== '0 || dist1 !== '0) begin errors++; $display("FAIL reset_dist got %0d/%0d required 0/0", dist0, dist1); end
        checks++;
        if (busy !== 1'b0 || sel !== 1'b0) begin errors++; $display("FAIL reset_ctl got busy=%b sel=%b required 0/0", busy, sel); end
    endtask

    task automatic test_first_slot();
        int n;
        enable = 1'b1;
        RESET  = 1'b0;
        n = 0;
        while (!trig[0] && n < 10) begin @(negedge CLK); n++; end
        checks++;
        if (n != 1) begin errors++; $display("FAIL first_trig_delay got %0d required 1", n); end
        run_slot(0, 10, 21, 1'b0);
    endtask

    // The valid pulse lands in the first gap cycle and the single-pulse check
    // consumed it, so GAP_CYCLES-1 cycles remain before the other trigger.
    task automatic test_gap_to_sensor1();
        int n;
        n = 0;
        while (!trig[1] && n < 30) begin @(negedge CLK); n++; end
        checks++;
        if (n != GAP_CYCLES - 1) begin errors++; $display("FAIL gap_length got %0d required %0d", n, GAP_CYCLES - 1); end
    endtask

    task automatic test_rise_timeout();
        run_slot(1, 0, 0, 1'b0);
        run_slot(0, 5, 35, 1'b0);
        run_slot(0, 7, 17, 1'b0);
    endtask

    task automatic test_echo_timeout();
        run_slot(2, 6, 300, 1'b1);
    endtask

    task automatic test_enable_drop();
        run_slot(0, 4, 41, 1'b1);
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 10; i++) begin
            kind = (exp_tmo[exp_sel] || $urandom_range(0, 2) != 0) ? 0 : 1;
            run_slot(kind, $urandom_range(1, 30), 2 * $urandom_range(1, 75) + 1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_trig();
        int n;
        n = 0;
        while (trig == 2'b00 && n < 200) begin @(negedge CLK); n++; end
        checks++;
        if (trig == 2'b00) begin errors++; $display("FAIL reset_find_trig got no trigger required one"); end
        @(negedge CLK);
        RESET   = 1'b1;
        echo[1] = 1'($urandom_range(0, 1));
        @(negedge CLK);
        checks++;
        if (trig !== 2'b00 || valid !== 2'b00 || tmo !== 2'b00 || busy !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctl got trig=%b valid=%b tmo=%b busy=%b sel=%b required all 0", trig, valid, tmo, busy, sel);
        end
        checks++;
        if (dist0 !== '0 || dist1 !== '0) begin errors++; $display("FAIL midreset_dist got %0d/%0d required 0/0", dist0, dist1); end
        repeat (3) begin
            echo[1] = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        exp_dist[0] = '0;
        exp_dist[1] = '0;
        exp_tmo = 2'b00;
        exp_sel = 0;
        RESET = 1'b0;
        run_slot(0, 9, 27, 1'b0);
        run_slot(0, 3, 13, 1'b0);
    endtask

    task automatic test_trig_exclusive();
        checks++;
        if (both_trig != 0) begin errors++; $display("FAIL trig_exclusive got %0d double-trigger cycles required 0", both_trig); end
    endtask

    initial begin
        vcnt[0] = 0;
        vcnt[1] = 0;
        test_reset();
        test_first_slot();
        test_gap_to_sensor1();
        test_rise_timeout();
        test_echo_timeout();
        test_enable_drop();
        test_random();
        test_reset_mid_trig();
        test_trig_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
- Time-multiplexes two HC-SR04-style ultrasonic sensors (pitch and volume hands) so their pings never overlap and never cross-talk.
- Per slot: issues one trigger pulse, measures the echo pulse width, converts it to distance units, then waits a quiet gap before the other sensor's slot.
- Sits between the sensor pins and the tone/volume datapath.
- Provides per-sensor distance registers, one-cycle update strobes and timeout flags.

Parameters:
- TRIG_CYCLES, 1000, trigger high time in clock cycles (10 us at 100 MHz).
- DIV, 100, echo-high clock cycles per distance unit.
- RISE_TIMEOUT, 100000, max cycles from trigger fall to echo rise.
- ECHO_TIMEOUT, 2500000, max echo-high cycles before abort.
- GAP_CYCLES, 500000, quiet cycles after each slot before the next slot starts.
- DW, 16, distance register width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- enable  in  1  run the ping schedule; when low, the scheduler parks in IDLE after finishing the current slot
- echo  in  2  raw echo pins, asynchronous; bit i belongs to sensor i
- trig  out  2  trigger pins, bit i drives sensor i
- dist0  out  DW  last valid distance of sensor 0
- dist1  out  DW  last valid distance of sensor 1
- valid  out  2  one-cycle strobe; bit i pulses when dist_i updates
- tmo  out  2  sticky timeout flag for sensor i; cleared on the next valid for that sensor
- busy  out  1  high whenever state is not IDLE
- sel  out  1  sensor currently owning the slot

Behaviour:
- Reset: the following apply on any cycle with RESET=1, including mid-slot.
  - All outputs go to 0: trig=0, dist0=dist1=0, valid=0, tmo=0, busy=0, sel=0.
  - FSM goes to IDLE; all counters clear.
  - Echo synchronizer flops clear to 0.
- Echo synchronization:
  - Each echo bit passes through 2 flops; the FSM sees only the synchronized value es.
  - An edge on the pin is therefore visible 2 cycles later.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE:
  - Moves to TRIG when enable=1.
  - sel is not changed in IDLE.
- TRIG:
  - trig[sel]=1 for exactly TRIG_CYCLES cycles.
  - The other trig bit is always 0.
  - Then moves to WAIT_RISE with the counter cleared.
- WAIT_RISE:
  - es[sel]=1 moves to MEASURE; the cycle counter and distance accumulator clear.
  - If the counter reaches RISE_TIMEOUT first: set tmo[sel], keep dist, move to GAP.
- MEASURE, per cycle while es[sel]=1:
  - The prescaler counts 0..DIV-1.
  - On wrap, the accumulator increments, saturating at 2^DW-1.
- MEASURE, on es[sel]=0 (falling edge):
  - dist_sel is loaded from the accumulator, truncated toward zero (partial DIV is discarded).
  - valid[sel] pulses on the next cycle, aligned with the new dist value.
  - tmo[sel] clears.
  - Move to GAP.
- MEASURE, if echo-high cycles reach ECHO_TIMEOUT:
  - Set tmo[sel]; dist and valid are untouched.
  - Move to GAP.
- GAP:
  - Waits GAP_CYCLES with all trig=0.
  - On exit, sel toggles.
  - Then moves to TRIG if enable=1, else to IDLE.
- Echo on the non-selected sensor is ignored in every state.
- Echo already high on entry to WAIT_RISE is treated as an immediate rise; the bench must not depend on this.
- enable is sampled only at IDLE exit and GAP exit; deasserting it never truncates a slot.
- Simultaneous falling edge and ECHO_TIMEOUT in the same cycle: the valid measurement wins.
- Counters are sized to hold max(RISE_TIMEOUT, ECHO_TIMEOUT, GAP_CYCLES) and never wrap.
- No division is performed; distance comes solely from the prescaler/accumulator.

Test Plan:
Parameters for all tests: TRIG_CYCLES=4, DIV=2, RISE_TIMEOUT=50, ECHO_TIMEOUT=200, GAP_CYCLES=8, DW=16.
1. Reset release with enable=1 -> trig[0] high for exactly 4 cycles starting 1 cycle after IDLE exit; trig[1]=0 throughout; busy=1.
2. Sensor 0: echo rises 10 cycles after trig falls and stays high 21 cycles -> dist0=10, valid[0] single pulse, tmo[0]=0; after the 8-cycle gap, trig[1] pulses.
3. Sensor 1: no echo -> tmo[1]=1 after 50 WAIT_RISE cycles; dist1 unchanged; schedule returns to sensor 0; the next good sensor 1 measurement clears tmo[1].
4. Echo held high 300 cycles -> tmo[sel]=1 at 200 echo-high cycles; no valid pulse; slot ends and the scheduler still advances.
5. enable dropped mid-MEASURE -> the measurement completes, valid pulses, GAP runs, then IDLE with busy=0; re-enabling starts the opposite sensor.
6. RESET asserted mid-TRIG with echo[1] toggling -> next cycle all outputs are 0; after release the first trigger is on sensor 0; echo on the idle sensor never produces valid.
